uart_transmitter: RTL and testbench

Serialises one byte per write into an 11-bit UART frame on TxD: start (0), 8 data bits LSB first, even parity, stop (1). It is the transmit end of the channel whose receive end is uart_receiver. Both ends share the baud_select encoding, 16x oversample timing, frame format and parity rule, so TxD can drive RxD directly for loopback. System clock is 50 MHz.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_transmitter_if.sv | 11 +
 rtl/baud_controller.sv | 21 ++
 rtl/uart_transmitter.sv | 75 +++++++
 tb/tb_uart_transmitter.sv | 127 ++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, FSM states and baud divisor lookup.
// Used by both uart_transmitter and uart_receiver so the two ends always agree on timing.
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;
   localparam logic [2:0] BAUD_300    = 3'b000;
   localparam logic [2:0] BAUD_1200   = 3'b001;
   localparam logic [2:0] BAUD_4800   = 3'b010;
   localparam logic [2:0] BAUD_9600   = 3'b011;
   localparam logic [2:0] BAUD_19200  = 3'b100;
   localparam logic [2:0] BAUD_38400  = 3'b101;
   localparam logic [2:0] BAUD_57600  = 3'b110;
   localparam logic [2:0] BAUD_115200 = 3'b111;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   // Clock cycles per sample tick, rounded to nearest.
   function automatic logic [15:0] divisor(input logic [2:0] code, input int clk_hz, input int os);
      int baud;
      baud = code == BAUD_300    ? 300    :
             code == BAUD_1200   ? 1200   :
             code == BAUD_4800   ? 4800   :
             code == BAUD_9600   ? 9600   :
             code == BAUD_19200  ? 19200  :
             code == BAUD_38400  ? 38400  :
             code == BAUD_57600  ? 57600  : 115200;
      return 16'((clk_hz + os * baud / 2) / (os * baud));
   endfunction
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: write port and serial line of the UART transmitter.
interface uart_transmitter_if;
   logic [2:0] baud_select;
   logic       Tx_EN;
   logic       Tx_WR;
   logic [7:0] Tx_DATA;
   logic       TxD;
   logic       Tx_BUSY;
   modport master (output baud_select, Tx_EN, Tx_WR, Tx_DATA, input TxD, Tx_BUSY);
   modport slave  (input baud_select, Tx_EN, Tx_WR, Tx_DATA, output TxD, Tx_BUSY);
endinterface

// File: rtl/baud_controller.sv
// baud_controller: one-cycle oversample tick every divisor(baud_select) clocks.
// restart zeroes the counter so a frame's first bit gets a full bit time.
module baud_controller
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic       reset,
   input  logic       clk,
   input  logic [2:0] baud_select,
   input  logic       restart,
   output logic       sample_ENABLE
);
   logic [15:0] cnt, div;
   assign div = divisor(baud_select, CLK_HZ, OVERSAMPLE);
   assign sample_ENABLE = cnt == div - 16'd1;
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= (restart || sample_ENABLE) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: sends one byte per accepted write as start, 8 data LSB first, even parity, stop.
// Data, parity and baud code are latched at acceptance so later input changes cannot disturb a frame.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input logic          clk,
   input logic          reset,
   uart_transmitter_if.slave tx
);
   state_t     state;
   logic [3:0] ticks;
   logic [2:0] idx, baud;
   logic [7:0] data;
   logic       par, txd, busy, tick, accept;
   assign accept = tx.Tx_WR && tx.Tx_EN && !busy;
   assign tx.TxD = txd;
   assign tx.Tx_BUSY = busy;
   baud_controller #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(OVERSAMPLE)) u_baud (
      .reset(reset),
      .clk(clk),
      .baud_select(baud),
      .restart(accept),
      .sample_ENABLE(tick)
   );
   // Each state lasts OVERSAMPLE ticks; txd is loaded with the next bit on the wrapping tick.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         ticks <= '0;
         idx   <= '0;
         baud  <= '0;
         data  <= '0;
         par   <= 1'b0;
         txd   <= 1'b1;
         busy  <= 1'b0;
      end else if (state == IDLE) begin
         if (accept) begin
            state <= START;
            ticks <= '0;
            idx   <= '0;
            baud  <= tx.baud_select;
            data  <= tx.Tx_DATA;
            par   <= ^tx.Tx_DATA;
            txd   <= 1'b0;
            busy  <= 1'b1;
         end
      end else if (tick) begin
         ticks <= ticks == 4'(OVERSAMPLE - 1) ? 4'd0 : ticks + 4'd1;
         if (ticks == 4'(OVERSAMPLE - 1))
            case (state)
               START: begin
                  state <= DATA;
                  idx   <= '0;
                  txd   <= data[0];
               end
               DATA: begin
                  state <= idx == 3'd7 ? PARITY : DATA;
                  idx   <= idx + 3'd1;
                  txd   <= idx == 3'd7 ? par : data[idx + 3'd1];
               end
               PARITY: begin
                  state <= STOP;
                  txd   <= 1'b1;
               end
               default: begin
                  state <= IDLE;
                  txd   <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
      end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed and random frames checked against a bit-level frame model.
`timescale 1ns/1ps
module tb_uart_transmitter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   int div_tab [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};
   logic [7:0] r;

   uart_transmitter_if tx();
   uart_transmitter #(.CLK_HZ(50000000), .OVERSAMPLE(16)) dut (.clk(clk), .reset(reset), .tx(tx));

   always #10 clk = ~clk;

   // Frame as transmitted, index 0 first on the wire.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      return {1'b1, ^d, d, 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk(input string tag, input int n);
      repeat (n) begin
         cyc();
         chk({tag, "_txd"}, 16'(tx.TxD), 16'd1);
         chk({tag, "_busy"}, 16'(tx.Tx_BUSY), 16'd0);
      end
   endtask

   // Writes d at rate code, then checks the first and last cycle of every bit for `limit`
   // cycles (0 = whole frame). disturb adds a busy write, baud change and Tx_EN drop mid-frame;
   // end_wr raises Tx_WR in the last busy cycle.
   task automatic run_frame(input logic [7:0] d, input logic [2:0] code, input bit disturb,
                            input bit end_wr, input int limit);
      int bt;
      int last;
      logic [10:0] f;
      bt = 16 * div_tab[code];
      last = limit > 0 ? limit : 11 * bt;
      f = frame_of(d);
      tx.Tx_DATA = d;
      tx.baud_select = code;
      tx.Tx_EN = 1'b1;
      tx.Tx_WR = 1'b1;
      cyc();
      tx.Tx_WR = 1'b0;
      for (int c = 1; c <= last; c++) begin
         if (c > 1) cyc();
         if ((c - 1) % bt == 0 || c % bt == 0) begin
            chk($sformatf("txd_bit%0d", (c - 1) / bt), 16'(tx.TxD), 16'(f[(c - 1) / bt]));
            chk("busy_in_frame", 16'(tx.Tx_BUSY), 16'd1);
         end
         if (disturb && c == 4 * bt) begin
            tx.Tx_WR = 1'b1;
            tx.Tx_DATA = 8'h33;
            tx.baud_select = code == 3'd7 ? 3'd0 : 3'd7;
         end
         if (disturb && c == 4 * bt + 1) begin
            tx.Tx_WR = 1'b0;
            tx.Tx_EN = 1'b0;
         end
         if (disturb && c == 6 * bt) tx.Tx_EN = 1'b1;
         if (end_wr && c == 11 * bt) begin
            tx.Tx_WR = 1'b1;
            tx.Tx_DATA = 8'hC3;
         end
      end
   endtask

   initial begin
      tx.Tx_WR = 1'b0;
      tx.Tx_EN = 1'b0;
      tx.Tx_DATA = 8'h00;
      tx.baud_select = 3'd0;
      repeat (3) cyc();
      chk("reset_txd", 16'(tx.TxD), 16'd1);
      chk("reset_busy", 16'(tx.Tx_BUSY), 16'd0);
      reset = 1'b1;
      cyc();
      tx.Tx_WR = 1'b1;
      tx.Tx_DATA = 8'h5A;
      tx.baud_select = 3'd7;
      cyc();
      tx.Tx_WR = 1'b0;
      idle_chk("en_off", 40);
      run_frame(8'hA5, 3'd7, 1'b1, 1'b1, 0);
      cyc();
      chk("end_drop_txd", 16'(tx.TxD), 16'd1);
      chk("end_drop_busy", 16'(tx.Tx_BUSY), 16'd0);
      r = 8'($urandom);
      run_frame(r, 3'd7, 1'b0, 1'b1, 0);
      cyc();
      chk("gap_txd", 16'(tx.TxD), 16'd1);
      chk("gap_busy", 16'(tx.Tx_BUSY), 16'd0);
      r = 8'($urandom);
      run_frame(r, 3'd7, 1'b0, 1'b0, 0);
      idle_chk("after_b2b", 20);
      run_frame(8'h0B, 3'd3, 1'b1, 1'b0, 0);
      idle_chk("after_9600", 20);
      r = 8'($urandom);
      run_frame(r, 3'd7, 1'b0, 1'b0, 4 * 432 + 216);
      reset = 1'b0;
      #1;
      chk("async_rst_txd", 16'(tx.TxD), 16'd1);
      chk("async_rst_busy", 16'(tx.Tx_BUSY), 16'd0);
      repeat (4) cyc();
      reset = 1'b1;
      idle_chk("post_rst", 200);
      r = 8'($urandom);
      run_frame(r, 3'd7, 1'b0, 1'b0, 0);
      idle_chk("final", 5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
